trace_tx: RTL and testbench

TRACE_TX -- requirements
Module: trace_tx

---
 rtl/trace_tx.sv | 153 +++++++++++++++
 tb/tb_trace_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_tx.sv
// Pipeline trace transmitter: captures per-cycle PC/stall/flush records into a FIFO
// and streams each record as a header word followed by a PC word over valid/ready.
module trace_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_CYCLES = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        hazard_nop_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        branch_eq_i,
  input  logic        trace_ready_i,
  output logic        trace_valid_o,
  output logic [31:0] trace_data_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [15:0] drop_cnt_o,
  output logic        overflow_o,
  output logic        done_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = 50;

  typedef logic [AW:0]   ptr_t;
  typedef logic [RW-1:0] rec_t;
  typedef enum logic [1:0] {IDLE, HDR, PC} state_t;

  // Record layout: {cycle index [15:0], stall_ev, flush_ev, pc[31:0]}
  rec_t        mem [FIFO_DEPTH];
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  ptr_t        count;
  logic [AW-1:0] rd_next_idx;
  state_t      state;
  logic [31:0] pc_hold;

  logic capture;
  logic stall_ev;
  logic flush_ev;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  rec_t rec_in;
  rec_t rec_head;
  rec_t rec_next;

  function automatic logic [31:0] hdr_word(input rec_t rec);
    return {rec[49:34], rec[33], rec[32], 14'b0};
  endfunction

  assign count       = wr_ptr - rd_ptr;
  assign empty       = (count == '0);
  assign full        = (count == ptr_t'(FIFO_DEPTH));
  assign capture     = start_i & ~done_o;
  assign stall_ev    = hazard_nop_i & ~jump_i & ~branch_i;
  assign flush_ev    = (branch_i & branch_eq_i) | jump_i;
  assign pop         = (state == PC) & trace_ready_i;
  // A full FIFO still accepts the new record when the head pops on the same edge.
  assign push        = capture & (~full | pop);
  assign drop        = capture & full & ~pop;
  assign rec_in      = {cycle_cnt_o[15:0], stall_ev, flush_ev, pc_i};
  assign rd_next_idx = rd_ptr[AW-1:0] + AW'(1);
  assign rec_head    = mem[rd_ptr[AW-1:0]];
  assign rec_next    = mem[rd_next_idx];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= rec_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr      <= '0;
      cycle_cnt_o <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      drop_cnt_o  <= '0;
      overflow_o  <= 1'b0;
      done_o      <= 1'b0;
    end else if (capture) begin
      cycle_cnt_o <= cycle_cnt_o + 32'd1;
      stall_cnt_o <= stall_cnt_o + {31'd0, stall_ev};
      flush_cnt_o <= flush_cnt_o + {31'd0, flush_ev};
      if (cycle_cnt_o + 32'd1 == 32'(MAX_CYCLES)) begin
        done_o <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) begin
          drop_cnt_o <= drop_cnt_o + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      pc_hold       <= '0;
      trace_valid_o <= 1'b0;
      trace_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            trace_data_o  <= hdr_word(rec_head);
            pc_hold       <= rec_head[31:0];
            trace_valid_o <= 1'b1;
            state         <= HDR;
          end
        end
        HDR: begin
          if (trace_ready_i) begin
            trace_data_o <= pc_hold;
            state        <= PC;
          end
        end
        PC: begin
          if (trace_ready_i) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
            // Head is popping now, so the following entry is loaded directly for a bubble-free stream.
            if (count > ptr_t'(1)) begin
              trace_data_o <= hdr_word(rec_next);
              pc_hold      <= rec_next[31:0];
              state        <= HDR;
            end else begin
              trace_data_o  <= '0;
              trace_valid_o <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: begin
          trace_valid_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_tx.sv
// Directed bench for trace_tx: steady capture, events, backpressure, mid-run reset, start gating.
module tb_trace_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        hazard_nop_i;
  logic        jump_i;
  logic        branch_i;
  logic        branch_eq_i;
  logic        trace_ready_i;
  logic        trace_valid_o;
  logic [31:0] trace_data_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [15:0] drop_cnt_o;
  logic        overflow_o;
  logic        done_o;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] q[$];

  trace_tx #(.FIFO_DEPTH(8), .MAX_CYCLES(30)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .hazard_nop_i(hazard_nop_i), .jump_i(jump_i), .branch_i(branch_i),
    .branch_eq_i(branch_eq_i), .trace_ready_i(trace_ready_i),
    .trace_valid_o(trace_valid_o), .trace_data_o(trace_data_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 ns after posedge, so valid&ready seen here means a handshake at the next posedge.
  always @(negedge clk_i) begin
    if (rst_i && trace_valid_o && trace_ready_i) q.push_back(trace_data_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; pc_i = '0; hazard_nop_i = 1'b0; jump_i = 1'b0;
    branch_i = 1'b0; branch_eq_i = 1'b0; trace_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b0;
    step();
    step();
    q.delete();
    rst_i = 1'b1;
  endtask

  task automatic drain(input int unsigned n, input string tag);
    int unsigned k = 0;
    while ((q.size() < n || trace_valid_o) && k < 200) begin
      step();
      k++;
    end
    chk({tag, "_words"}, 32'(q.size()), n);
    repeat (3) step();
    chk({tag, "_nomore"}, 32'(q.size()), n);
  endtask

  task automatic chk_rec(input string tag, input int unsigned r, input logic [31:0] hdr, input logic [31:0] pc);
    logic [31:0] h = '0;
    logic [31:0] p = '0;
    if (q.size() > 2 * r + 1) begin
      h = q[2*r];
      p = q[2*r+1];
    end
    chk({tag, "_hdr"}, h, hdr);
    chk({tag, "_pc"}, p, pc);
  endtask

  initial begin
    logic [31:0] ev_hdr [5];
    logic        ev_haz [5];
    logic        ev_jmp [5];
    logic        ev_br  [5];
    logic        ev_eq  [5];
    int unsigned idx;

    // Reset state
    idle_inputs();
    rst_i = 1'b0;
    step();
    step();
    chk("rst_valid", {31'd0, trace_valid_o}, 32'd0);
    chk("rst_data", trace_data_o, 32'd0);
    chk("rst_cycle", cycle_cnt_o, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt_o}, 32'd0);
    chk("rst_flags", {30'd0, overflow_o, done_o}, 32'd0);
    rst_i = 1'b1;

    // Steady capture with ready high: FIFO fills, odd edges from 15 drop.
    start_i = 1'b1;
    trace_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pc_i = 32'(4 * i);
      step();
      if (i == 0) chk("lat_edge1_valid", {31'd0, trace_valid_o}, 32'd0);
      if (i == 1) begin
        chk("lat_edge2_valid", {31'd0, trace_valid_o}, 32'd1);
        chk("lat_edge2_hdr", trace_data_o, 32'h0000_0000);
      end
      if (i == 28) chk("pre_done", {31'd0, done_o}, 32'd0);
    end
    chk("steady_done", {31'd0, done_o}, 32'd1);
    chk("steady_cycle", cycle_cnt_o, 32'd30);
    chk("steady_drop", {16'd0, drop_cnt_o}, 32'd8);
    chk("steady_ovf", {31'd0, overflow_o}, 32'd1);
    pc_i = 32'hDEAD_BEEF;
    drain(44, "steady");
    chk("steady_cycle_frozen", cycle_cnt_o, 32'd30);
    for (int r = 0; r < 22; r++) begin
      idx = (r < 14) ? 32'(r) : 32'(15 + 2 * (r - 14));
      chk_rec("steady_rec", r, {idx[15:0], 16'h0000}, 4 * idx);
    end

    // Stall / flush events
    do_reset();
    ev_haz = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    ev_jmp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ev_br  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ev_eq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ev_hdr = '{32'h0000_8000, 32'h0001_8000, 32'h0002_4000, 32'h0003_4000, 32'h0004_0000};
    start_i = 1'b1;
    trace_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_i = 32'h100 + 32'(4 * i);
      hazard_nop_i = ev_haz[i]; jump_i = ev_jmp[i];
      branch_i = ev_br[i]; branch_eq_i = ev_eq[i];
      step();
    end
    start_i = 1'b0; hazard_nop_i = 1'b0; jump_i = 1'b0; branch_i = 1'b0; branch_eq_i = 1'b0;
    chk("ev_stall", stall_cnt_o, 32'd2);
    chk("ev_flush", flush_cnt_o, 32'd2);
    chk("ev_cycle", cycle_cnt_o, 32'd5);
    drain(10, "ev");
    chk("ev_drop", {16'd0, drop_cnt_o}, 32'd0);
    for (int r = 0; r < 5; r++) chk_rec("ev_rec", r, ev_hdr[r], 32'h100 + 32'(4 * r));

    // Backpressure: 12 captures with ready low
    do_reset();
    start_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      pc_i = 32'h2000 + 32'(4 * i);
      step();
      if (i >= 1) begin
        chk("bp_hold_valid", {31'd0, trace_valid_o}, 32'd1);
        chk("bp_hold_data", trace_data_o, 32'h0000_0000);
      end
    end
    start_i = 1'b0;
    chk("bp_drop", {16'd0, drop_cnt_o}, 32'd4);
    chk("bp_ovf", {31'd0, overflow_o}, 32'd1);
    chk("bp_cycle", cycle_cnt_o, 32'd12);
    step();
    chk("bp_hold_late", trace_data_o, 32'h0000_0000);
    trace_ready_i = 1'b1;
    drain(16, "bp");
    for (int r = 0; r < 8; r++) chk_rec("bp_rec", r, {16'(r), 16'h0000}, 32'h2000 + 32'(4 * r));

    // Mid-run reset while in HDR
    do_reset();
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h50 + 32'(i);
      hazard_nop_i = 1'b1;
      step();
    end
    chk("mr_pre_valid", {31'd0, trace_valid_o}, 32'd1);
    chk("mr_pre_stall", stall_cnt_o, 32'd3);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mr_valid", {31'd0, trace_valid_o}, 32'd0);
    chk("mr_data", trace_data_o, 32'd0);
    chk("mr_cycle", cycle_cnt_o, 32'd0);
    chk("mr_stall", stall_cnt_o, 32'd0);
    idle_inputs();
    step();
    step();
    q.delete();
    rst_i = 1'b1;
    start_i = 1'b1;
    trace_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pc_i = 32'h3000 + 32'(4 * i);
      step();
    end
    start_i = 1'b0;
    drain(4, "mr");
    chk_rec("mr_first", 0, 32'h0000_0000, 32'h3000);
    chk_rec("mr_second", 1, 32'h0001_0000, 32'h3004);

    // Start gating mid-run
    do_reset();
    trace_ready_i = 1'b1;
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'h4000 + 32'(4 * i);
      step();
    end
    start_i = 1'b0;
    pc_i = 32'hFFFF_0000;
    repeat (5) step();
    chk("gate_cycle", cycle_cnt_o, 32'd3);
    chk("gate_drained", 32'(q.size()), 32'd6);
    chk("gate_idle", {31'd0, trace_valid_o}, 32'd0);
    start_i = 1'b1;
    for (int i = 3; i < 5; i++) begin
      pc_i = 32'h4000 + 32'(4 * i);
      step();
    end
    start_i = 1'b0;
    chk("gate_cycle_end", cycle_cnt_o, 32'd5);
    drain(10, "gate");
    for (int r = 0; r < 5; r++) chk_rec("gate_rec", r, {16'(r), 16'h0000}, 32'h4000 + 32'(4 * r));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
